// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD up/down timer: FSM encoding, digit limit
// and the preset clamping helpers used at reset and on load.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Any nibble above 9 is not a decimal digit; saturate it to 9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    clamp_digit = (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // Clamp every nibble of a packed BCD word (up to 8 digits).
  function automatic logic [31:0] clamp_bcd(input logic [31:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = clamp_digit(v[4*i +: 4]);
    end
    return r;
  endfunction

endpackage

// File: rtl/SSD_Decoder.sv
// Per-digit segment decoder. Bit order: [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f
// [6]=g1 [7]=g2 [13:8]=inner diagonal/vertical segments [14]=dp.
// Decimal digits use only the outer ring and the middle bar; codes above 9
// blank the digit.
module SSD_Decoder (
  input  logic [3:0]  digit,
  output logic [14:0] pattern
);

  // Pure lookup from BCD digit to segment pattern.
  always_comb begin
    pattern = 15'h0000;
    case (digit)
      4'd0:    pattern = 15'h003F;
      4'd1:    pattern = 15'h0006;
      4'd2:    pattern = 15'h00DB;
      4'd3:    pattern = 15'h00CF;
      4'd4:    pattern = 15'h00E6;
      4'd5:    pattern = 15'h00ED;
      4'd6:    pattern = 15'h00FD;
      4'd7:    pattern = 15'h0007;
      4'd8:    pattern = 15'h00FF;
      4'd9:    pattern = 15'h00EF;
      default: pattern = 15'h0000;
    endcase
  end

endmodule

// File: rtl/bcd_digit.sv
// One decimal digit of the timer: 4-bit register with load, and a single
// +/-1 step that is only taken when the carry/borrow chain reaches this digit.
module bcd_digit
  import bcd_countdown_timer_pkg::*;
#(
  parameter logic [3:0] RST_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       step,
  input  logic       up,
  input  logic       cin,
  output logic       cout,
  output logic [3:0] value,
  output logic [3:0] value_next,
  output logic       is_zero
);

  logic [3:0] value_r;
  logic       is_nine_s;

  assign is_zero   = (value_r == 4'd0);
  assign is_nine_s = (value_r == BCD_MAX);
  // Carry (up) leaves at 9, borrow (down) leaves at 0, only if one arrived.
  assign cout      = cin & (up ? is_nine_s : is_zero);
  assign value     = value_r;

  // Value this digit takes if the step is committed on the coming edge.
  always_comb begin
    value_next = value_r;
    if (step && cin) begin
      if (up) begin
        value_next = is_nine_s ? 4'd0 : (value_r + 4'd1);
      end else begin
        value_next = is_zero ? BCD_MAX : (value_r - 4'd1);
      end
    end else begin
      value_next = value_r;
    end
  end

  // Digit register: load beats stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= RST_VAL;
    end else if (load) begin
      value_r <= load_val;
    end else begin
      value_r <= value_next;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD up/down timer. Counts one step per external tick while running,
// stops at 0 (down) or at the latched target (up), and then lights the LED
// bank. Load restarts from the preset in IDLE; only load or reset leaves DONE.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int                      DIGITS     = 2,
  parameter logic [4*DIGITS-1:0]     PRESET_RST = 8'h30,
  parameter int                      LED_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  start,
  input  logic                  enable,
  input  logic                  dir,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [15*DIGITS-1:0]  ssd,
  output logic [LED_W-1:0]      led,
  output logic                  running,
  output logic                  done,
  output logic                  done_pulse
);

  localparam logic [31:0]         RST_WIDE  = clamp_bcd(32'(PRESET_RST));
  localparam logic [4*DIGITS-1:0] RST_CLAMP = RST_WIDE[4*DIGITS-1:0];
  localparam logic [4*DIGITS-1:0] ZERO_CNT  = {(4*DIGITS){1'b0}};

  state_t                state_r, state_next_s;
  logic [4*DIGITS-1:0]   target_r;
  logic                  mode_r;
  logic [4*DIGITS-1:0]   count_s, next_count_s;
  logic [4*DIGITS-1:0]   preset_clamp_s, load_val_s;
  logic [DIGITS-1:0]     is_zero_s;
  logic [DIGITS:0]       carry_s;
  logic                  step_s, wrap_s, term_now_s, term_next_s;
  logic                  running_r, done_r, done_pulse_r;
  logic [LED_W-1:0]      led_r;

  assign carry_s[0] = 1'b1;
  // A carry/borrow out of the top digit means the step would wrap around.
  assign wrap_s     = carry_s[DIGITS];
  assign load_val_s = dir ? ZERO_CNT : preset_clamp_s;
  assign step_s     = (state_r == ST_RUN) && tick && enable && !load && !wrap_s;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign preset_clamp_s[4*i +: 4] = clamp_digit(preset[4*i +: 4]);

    bcd_digit #(
      .RST_VAL (RST_CLAMP[4*i +: 4])
    ) u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .load_val   (load_val_s[4*i +: 4]),
      .step       (step_s),
      .up         (mode_r),
      .cin        (carry_s[i]),
      .cout       (carry_s[i+1]),
      .value      (count_s[4*i +: 4]),
      .value_next (next_count_s[4*i +: 4]),
      .is_zero    (is_zero_s[i])
    );

    SSD_Decoder u_ssd (
      .digit   (count_s[4*i +: 4]),
      .pattern (ssd[15*i +: 15])
    );
  end

  // Terminal compare on the present count (for start) and the stepped count.
  always_comb begin
    term_now_s  = 1'b0;
    term_next_s = 1'b0;
    if (mode_r) begin
      term_now_s  = (count_s == target_r);
      term_next_s = (next_count_s == target_r);
    end else begin
      term_now_s  = &is_zero_s;
      term_next_s = (next_count_s == ZERO_CNT);
    end
  end

  // Next-state logic: load > start > tick.
  always_comb begin
    state_next_s = state_r;
    if (load) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_next_s = term_now_s ? ST_DONE : ST_RUN;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (step_s && term_next_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_DONE: state_next_s = ST_DONE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Target and count direction, captured together with the preset on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_r <= RST_CLAMP;
      mode_r   <= 1'b0;
    end else if (load) begin
      target_r <= preset_clamp_s;
      mode_r   <= dir;
    end else begin
      target_r <= target_r;
      mode_r   <= mode_r;
    end
  end

  // Status outputs registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_r    <= 1'b0;
      done_r       <= 1'b0;
      done_pulse_r <= 1'b0;
      led_r        <= {LED_W{1'b0}};
    end else begin
      running_r    <= (state_next_s == ST_RUN);
      done_r       <= (state_next_s == ST_DONE);
      done_pulse_r <= (state_next_s == ST_DONE) && (state_r != ST_DONE);
      led_r        <= {LED_W{state_next_s == ST_DONE}};
    end
  end

  assign bcd        = count_s;
  assign led        = led_r;
  assign running    = running_r;
  assign done       = done_r;
  assign done_pulse = done_pulse_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for the BCD timer: a 2-digit instance exercising every
// control path and a 4-digit instance checking the multi-digit borrow.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick = 1'b0, load = 1'b0, start = 1'b0, enable = 1'b1, dir = 1'b0;
  logic [7:0]  preset = 8'h00;
  logic [7:0]  bcd;
  logic [29:0] ssd;
  logic [15:0] led;
  logic        running, done, done_pulse;

  logic        tick2 = 1'b0, load2 = 1'b0, start2 = 1'b0, enable2 = 1'b1, dir2 = 1'b0;
  logic [15:0] preset2 = 16'h0000;
  logic [15:0] bcd2;
  logic [59:0] ssd2;
  logic [15:0] led2;
  logic        running2, done2, done_pulse2;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_countdown_timer #(.DIGITS(2), .PRESET_RST(8'h30), .LED_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .preset(preset),
    .start(start), .enable(enable), .dir(dir), .bcd(bcd), .ssd(ssd),
    .led(led), .running(running), .done(done), .done_pulse(done_pulse)
  );

  bcd_countdown_timer #(.DIGITS(4), .PRESET_RST(16'h1000), .LED_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .tick(tick2), .load(load2), .preset(preset2),
    .start(start2), .enable(enable2), .dir(dir2), .bcd(bcd2), .ssd(ssd2),
    .led(led2), .running(running2), .done(done2), .done_pulse(done_pulse2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one active edge and settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] p, input logic d);
    load = 1'b1; preset = p; dir = d;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    logic [3:0] tens, ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  initial begin
    // 1: reset values, then full 30 -> 00 countdown
    #2 rst_n = 1'b0;
    #10;
    check("rst_bcd", 64'(bcd), 64'h30);
    check("rst_led", 64'(led), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_pulse", 64'(done_pulse), 64'h0);
    check("rst_running", 64'(running), 64'h0);
    check("rst_ssd", 64'(ssd), 64'({15'h00CF, 15'h003F}));
    check("rst_bcd4", 64'(bcd2), 64'h1000);
    @(negedge clk);
    rst_n = 1'b1;

    do_start();
    check("t1_running", 64'(running), 64'h1);
    for (int v = 29; v >= 0; v--) begin
      do_tick();
      check("t1_count", 64'(bcd), 64'(to_bcd2(v)));
    end
    check("t1_done", 64'(done), 64'h1);
    check("t1_led", 64'(led), 64'hFFFF);
    check("t1_pulse", 64'(done_pulse), 64'h1);
    check("t1_running_off", 64'(running), 64'h0);
    cyc();
    check("t1_pulse_drop", 64'(done_pulse), 64'h0);
    check("t1_done_hold", 64'(done), 64'h1);
    do_tick();
    check("t1_no_wrap", 64'(bcd), 64'h00);

    // 2: pause with enable low, then borrow 20 -> 19
    do_load(8'h20, 1'b0);
    check("t2_leave_done", 64'(done), 64'h0);
    do_start();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_tick();
    end
    check("t2_frozen", 64'(bcd), 64'h20);
    check("t2_running", 64'(running), 64'h1);
    enable = 1'b1;
    do_tick();
    check("t2_borrow", 64'(bcd), 64'h19);

    // 3: clamped load, tick ignored in IDLE
    do_load(8'h5C, 1'b0);
    check("t3_clamp", 64'(bcd), 64'h59);
    check("t3_idle", 64'(running), 64'h0);
    check("t3_ssd", 64'(ssd), 64'({15'h00ED, 15'h00EF}));
    do_tick();
    check("t3_idle_tick", 64'(bcd), 64'h59);

    // 4: count up to target 12
    do_load(8'h12, 1'b1);
    check("t4_up_start", 64'(bcd), 64'h00);
    do_start();
    for (int v = 1; v <= 12; v++) begin
      do_tick();
      check("t4_count", 64'(bcd), 64'(to_bcd2(v)));
    end
    check("t4_done", 64'(done), 64'h1);
    check("t4_pulse", 64'(done_pulse), 64'h1);
    do_tick();
    check("t4_hold", 64'(bcd), 64'h12);

    // 5: load beats tick in RUN; start at terminal goes straight to DONE
    do_load(8'h45, 1'b0);
    do_start();
    do_tick();
    check("t5_run", 64'(bcd), 64'h44);
    load = 1'b1; tick = 1'b1; preset = 8'h37; dir = 1'b0;
    cyc();
    load = 1'b0; tick = 1'b0;
    check("t5_load_wins", 64'(bcd), 64'h37);
    check("t5_idle", 64'(running), 64'h0);
    do_load(8'h00, 1'b0);
    do_start();
    check("t5_zero_done", 64'(done), 64'h1);
    check("t5_zero_pulse", 64'(done_pulse), 64'h1);
    check("t5_zero_led", 64'(led), 64'hFFFF);

    // 6: asynchronous reset mid-count
    do_load(8'h25, 1'b0);
    do_start();
    for (int k = 0; k < 8; k++) begin
      do_tick();
    end
    check("t6_at17", 64'(bcd), 64'h17);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_bcd", 64'(bcd), 64'h30);
    check("t6_async_led", 64'(led), 64'h0);
    check("t6_async_done", 64'(done), 64'h0);
    check("t6_async_running", 64'(running), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("t6_no_pulse", 64'(done_pulse), 64'h0);
    check("t6_idle_after", 64'(bcd), 64'h30);

    // 4-digit instance: 1000 -> 0999
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    check("d4_running", 64'(running2), 64'h1);
    tick2 = 1'b1;
    cyc();
    tick2 = 1'b0;
    check("d4_borrow", 64'(bcd2), 64'h0999);
    check("d4_not_done", 64'(done2), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
